// File: rtl/rotate_right_seq.sv
// Multi-cycle right rotator: one log2 barrel stage per BUSY cycle, result held until consumed.
// Optional build macro ROTATE_RIGHT_SEQ_SKIP_EN visits only the stages whose amount bit is set.
module rotate_right_seq #(
  parameter int W = 32
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_vld,
  output logic               in_rdy,
  input  logic [W-1:0]       in_x,
  input  logic [$clog2(W):0] in_n,
  output logic               out_vld,
  input  logic               out_rdy,
  output logic [W-1:0]       out_y
);
  localparam int L = $clog2(W);

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t         state, state_nxt;
  logic [W-1:0]   d;
  logic [L-1:0]   a;
  logic [L-1:0]   k;
  logic [L-1:0]   amt;
  logic           unused_n_msb;
  logic           accept;
  logic           stage_last;
  logic           start_busy;
  logic [L-1:0]   k_start;
  logic [L-1:0]   k_next;
  logic [W-1:0]   rot_stage [L];

  // The amount is taken mod W, so the extra MSB of in_n never matters.
  assign amt          = in_n[L-1:0];
  assign unused_n_msb = in_n[L];

  for (genvar g = 0; g < L; g++) begin : g_stage
    assign rot_stage[g] = {d[(1<<g)-1:0], d[W-1:(1<<g)]};
  end

`ifdef ROTATE_RIGHT_SEQ_SKIP_EN
  logic [L-1:0] first_k;
  logic [L-1:0] next_k;
  logic         next_found;

  always_comb begin
    first_k = '0;
    for (int i = L - 1; i >= 0; i--) begin
      if (amt[i]) first_k = L'(i);
    end
  end

  // Lowest set amount bit strictly above the current stage.
  always_comb begin
    next_found = 1'b0;
    next_k     = k;
    for (int i = L - 1; i >= 0; i--) begin
      if (a[i] && (L'(i) > k)) begin
        next_found = 1'b1;
        next_k     = L'(i);
      end
    end
  end

  assign stage_last = !next_found;
  assign start_busy = (amt != '0);
  assign k_start    = first_k;
  assign k_next     = next_k;
`else
  assign stage_last = (k == L'(L - 1));
  assign start_busy = 1'b1;
  assign k_start    = '0;
  assign k_next     = k + L'(1);
`endif

  assign in_rdy  = (state == IDLE);
  assign out_vld = (state == DONE);
  assign out_y   = d;
  assign accept  = in_vld && in_rdy;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (accept) state_nxt = start_busy ? BUSY : DONE;
      BUSY: if (stage_last) state_nxt = DONE;
      DONE: if (out_rdy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      d <= '0;
      a <= '0;
      k <= '0;
    end else if (accept) begin
      d <= in_x;
      a <= amt;
      k <= k_start;
    end else if (state == BUSY) begin
      if (a[k]) d <= rot_stage[k];
      k <= k_next;
    end
  end

endmodule

// File: tb/tb_rotate_right_seq.sv
// Bench for rotate_right_seq: directed vectors, multi-cycle corner sequences and random traffic.
module tb_rotate_right_seq;
  localparam int W = 32;

  logic          clk;
  logic          rst_n;
  logic          in_vld;
  logic          in_rdy;
  logic [W-1:0]  in_x;
  logic [5:0]    in_n;
  logic          out_vld;
  logic          out_rdy;
  logic [W-1:0]  out_y;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;

  rotate_right_seq #(.W(W)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_vld(in_vld), .in_rdy(in_rdy), .in_x(in_x), .in_n(in_n),
    .out_vld(out_vld), .out_rdy(out_rdy), .out_y(out_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] x;
    logic [5:0]  n;
    logic [31:0] y;
  } vec_t;

  vec_t vecs [10];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Each output bit i takes input bit (i + amt) mod W.
  function automatic logic [31:0] model_rotr(input logic [31:0] x, input logic [5:0] n);
    int amt;
    logic [31:0] y;
    amt = int'(n) % W;
    for (int i = 0; i < W; i++) y[i] = x[(i + amt) % W];
    return y;
  endfunction

  function automatic int model_lat(input logic [5:0] n);
    int amt;
    amt = int'(n) % W;
`ifdef ROTATE_RIGHT_SEQ_SKIP_EN
    return 1 + $countones(amt);
`else
    return $clog2(W) + 1;
`endif
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Presents a request and returns once it has been accepted (cursor in cycle t+1).
  task automatic send(input logic [31:0] x, input logic [5:0] n);
    int guard;
    guard  = 0;
    in_x   = x;
    in_n   = n;
    in_vld = 1'b1;
    while (!in_rdy && guard < 50) begin
      tick();
      guard++;
    end
    if (guard >= 50) chk("send_timeout", 64'(guard), 64'd0);
    tick();
    in_vld = 1'b0;
  endtask

  task automatic wait_out(output int lat);
    lat = 1;
    while (!out_vld && lat < 50) begin
      tick();
      lat++;
    end
    if (!out_vld) chk("out_timeout", 64'(out_vld), 64'd1);
  endtask

  task automatic run_one(input string name, input logic [31:0] x, input logic [5:0] n,
                         input logic [31:0] exp_y);
    int lat;
    out_rdy = 1'b1;
    send(x, n);
    wait_out(lat);
    chk({name, "_lat"}, 64'(lat), 64'(model_lat(n)));
    chk({name, "_y"}, 64'(out_y), 64'(exp_y));
    tick();
    chk({name, "_pulse"}, 64'(out_vld), 64'd0);
    chk({name, "_rdy"}, 64'(in_rdy), 64'd1);
  endtask

  initial begin
    int lat;
    int out_cyc;
    int acc_cyc;
    int guard;
    logic stable;
    logic [31:0] rx;
    logic [5:0]  rn;

    vecs[0] = '{32'h0000_0001, 6'd1,  32'h8000_0000};
    vecs[1] = '{32'h1234_5678, 6'd4,  32'h8123_4567};
    vecs[2] = '{32'h1234_5678, 6'd36, 32'h8123_4567};
    vecs[3] = '{32'h1234_5678, 6'd32, 32'h1234_5678};
    vecs[4] = '{32'hDEAD_BEEF, 6'd0,  32'hDEAD_BEEF};
    vecs[5] = '{32'h1234_5678, 6'h11, 32'h2B3C_091A};
    vecs[6] = '{32'h0000_0001, 6'd31, 32'h0000_0002};
    vecs[7] = '{32'h0000_00F0, 6'd3,  32'h0000_001E};
    vecs[8] = '{32'h8000_0000, 6'd63, 32'h0000_0001};
    vecs[9] = '{32'hDEAD_BEEF, 6'd8,  32'hEFDE_ADBE};

    rst_n   = 1'b0;
    in_vld  = 1'b1;
    in_x    = 32'hFFFF_FFFF;
    in_n    = 6'd5;
    out_rdy = 1'b1;
    repeat (3) tick();
    chk("rst_out_vld", 64'(out_vld), 64'd0);
    chk("rst_out_y", 64'(out_y), 64'd0);
    chk("rst_in_rdy", 64'(in_rdy), 64'd1);
    in_vld = 1'b0;
    rst_n  = 1'b1;
    tick();
    chk("post_rst_out_vld", 64'(out_vld), 64'd0);
    chk("post_rst_in_rdy", 64'(in_rdy), 64'd1);

    for (int i = 0; i < 10; i++) run_one($sformatf("vec%0d", i), vecs[i].x, vecs[i].n, vecs[i].y);

    // Back-pressure: result must hold and new requests must be ignored.
    out_rdy = 1'b0;
    send(32'hDEAD_BEEF, 6'd8);
    wait_out(lat);
    chk("bp_lat", 64'(lat), 64'(model_lat(6'd8)));
    in_vld = 1'b1;
    in_x   = 32'h1111_1111;
    in_n   = 6'd1;
    stable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      if (out_y !== 32'hEFDE_ADBE || out_vld !== 1'b1 || in_rdy !== 1'b0) stable = 1'b0;
      tick();
    end
    in_vld = 1'b0;
    chk("bp_hold", 64'(stable), 64'd1);
    chk("bp_y", 64'(out_y), 64'hEFDE_ADBE);
    out_rdy = 1'b1;
    tick();
    chk("bp_release_vld", 64'(out_vld), 64'd0);
    chk("bp_release_rdy", 64'(in_rdy), 64'd1);
    tick();

    // Back-to-back: second request held from the cycle after the first is accepted.
    send(32'h0000_00F0, 6'd3);
    in_x    = 32'h0000_00F0;
    in_n    = 6'd31;
    in_vld  = 1'b1;
    out_cyc = -1;
    acc_cyc = -1;
    guard   = 0;
    while (acc_cyc < 0 && guard < 50) begin
      if (out_vld) begin
        chk("b2b_first_y", 64'(out_y), 64'h0000_001E);
        out_cyc = cyc;
      end
      if (in_rdy) acc_cyc = cyc;
      tick();
      guard++;
    end
    in_vld = 1'b0;
    chk("b2b_accept_after_out", 64'(acc_cyc), 64'(out_cyc + 1));
    wait_out(lat);
    chk("b2b_second_lat", 64'(lat), 64'(model_lat(6'd31)));
    chk("b2b_second_y", 64'(out_y), 64'h0000_01E0);
    tick();

    // Reset in the third BUSY cycle abandons the operation.
    send(32'hDEAD_BEEF, 6'd7);
    tick();
    tick();
    rst_n = 1'b0;
    #1;
    chk("midrst_out_vld", 64'(out_vld), 64'd0);
    chk("midrst_out_y", 64'(out_y), 64'd0);
    chk("midrst_in_rdy", 64'(in_rdy), 64'd1);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    guard = 0;
    for (int i = 0; i < 8; i++) begin
      if (out_vld) guard++;
      tick();
    end
    chk("midrst_no_output", 64'(guard), 64'd0);
    run_one("after_rst", 32'h0000_0020, 6'd5, 32'h0000_0001);

    for (int i = 0; i < 40; i++) begin
      rx = $urandom;
      rn = 6'($urandom_range(0, 63));
      out_rdy = 1'b0;
      send(rx, rn);
      wait_out(lat);
      chk($sformatf("rnd%0d_lat", i), 64'(lat), 64'(model_lat(rn)));
      repeat ($urandom_range(0, 2)) tick();
      chk($sformatf("rnd%0d_y", i), 64'(out_y), 64'(model_rotr(rx, rn)));
      out_rdy = 1'b1;
      tick();
      chk($sformatf("rnd%0d_pulse", i), 64'(out_vld), 64'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not complete, cycle %0d", cyc);
    $fatal(1);
  end

endmodule

// File: doc/rotate_right_seq.md
# rotate_right_seq

Sequential right-rotator: accepts a W-bit word and a rotate amount over a valid/ready handshake. It rotates the word right by the amount using one log2 barrel stage per cycle, then holds the result on a valid/ready output until it is consumed. It is the right-rotating, multi-cycle counterpart to the team's combinational left-rotate. It is intended for datapaths where an area-cheap rotator is preferred over a single-cycle barrel. Bit 0 of the input moves toward bit W-1 when the word wraps.

## Interface
- W, 32, data width; must be a power of two, W >= 2; L = $clog2(W) stages
- clk  input  1  clock, all state on rising edge
- rst_n  input  1  asynchronous active-low reset
- in_vld  input  1  request valid
- in_rdy  output  1  request ready
- in_x  input  W  word to rotate
- in_n  input  $clog2(W)+1  rotate-right amount
- out_vld  output  1  result valid
- out_rdy  input  1  result ready
- out_y  output  W  rotated word

## Operation
- Effective amount: amt = in_n mod W, i.e. the low L bits of in_n. The MSB of in_n is ignored, so n = W is identity.
- Result: out_y = (x >> amt) | (x << (W - amt)), with the amt = 0 result equal to x.
- FSM states: IDLE, BUSY, DONE; 2-bit state register plus stage counter k (L bits), data register D (W), amount register A (L).
- IDLE: in_rdy = 1.
  - On in_vld && in_rdy: D <= in_x, A <= amt, k <= 0, go to BUSY.
  - in_x and in_n are sampled only on the handshake edge.
- BUSY: each cycle applies stage k:
  - if A[k], D <= rotr(D, 2^k); otherwise D is unchanged.
  - k <= k+1.
  - After stage L-1, go to DONE.
- DONE: out_vld = 1, out_y = D.
  - On out_rdy, go to IDLE.
  - While out_rdy = 0, out_y and out_vld hold stable.
- in_rdy = 1 only in IDLE. There is no accept in DONE, even when out_rdy = 1.
- out_y is driven from D at all times. It is meaningful only while out_vld = 1.

## Timing
- Reset values: state = IDLE, D = 0, A = 0, k = 0. Outputs: out_vld = 0, out_y = 0, in_rdy = 1.
- Reset is asynchronous on assertion and synchronously released. Reset mid-BUSY or mid-DONE abandons the operation with no output.
- Latency: if the handshake is in cycle t, out_vld rises in cycle t+L+1. For W = 32 that is t+6.
- Minimum initiation interval is L+2 cycles. The next request is accepted in the cycle after the out handshake.
- out_vld && out_rdy in cycle u: out_vld = 0 and in_rdy = 1 in cycle u+1.
- in_vld while not in IDLE is ignored. The sender must hold the request until in_rdy.
- in_vld asserted during reset is not accepted.

## Configuration
- ROTATE_RIGHT_SEQ_SKIP_EN defined:
  - BUSY visits only stages k where A[k] = 1. k jumps to the next set bit of A; after the highest set bit, go to DONE.
  - If amt = 0, the handshake goes straight to DONE.
  - Latency is t+1+popcount(amt).
- Undefined (default):
  - Fixed L BUSY cycles regardless of amt, as described above.
- The result value is identical in both builds.

## Test plan
- W = 32, in_x = 0x0000_0001, in_n = 1, out_rdy = 1 → out_y = 0x8000_0000, out_vld in cycle t+6, one cycle wide.
- in_x = 0x1234_5678, in_n = 4 → 0x8123_4567. in_n = 36 → 0x8123_4567. in_n = 32 → 0x1234_5678.
- Back-pressure: in_x = 0xDEAD_BEEF, in_n = 8, out_rdy = 0 for 10 cycles → out_y = 0xEFDE_ADBE held stable, in_rdy = 0 throughout. On out_rdy = 1, there is one out handshake, then in_rdy = 1 the next cycle.
- Back-to-back: two requests, in_n = 3 and in_n = 31 on 0x0000_00F0 → outputs 0x0000_001E then 0x0000_01E0, in order, and the second request is accepted only after the first out handshake.
- Reset mid-op: drop rst_n in the 3rd BUSY cycle → out_vld = 0, out_y = 0, in_rdy = 1 immediately. After release, a fresh request in_n = 5 on 0x0000_0020 → 0x0000_0001.
- SKIP_EN build: in_n = 0 → out_vld in cycle t+1. in_n = 0x11 → t+3. in_n = 31 → t+6. Values match the non-SKIP build.
